garp_mem_bus_port: RTL and testbench

- Parametrised successor to the fixed 24-lane, 2-bit memory bus of the Garp array.
- Sits between array rows and the memory system.
- Buffers lane-packed load/store requests in a request FIFO and issues them with valid/ready.
- Returns in-order load data through a credit-limited response FIFO, and holds the last returned word on a registered bus.

---
 rtl/garp_mem_bus_port_if.sv | 52 +++++
 rtl/garp_mem_bus_port.sv | 139 +++++++++++++
 tb/tb_garp_mem_bus_port.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/garp_mem_bus_port_if.sv
// Array/memory-side signal bundle for garp_mem_bus_port.
// The slave modport is the port block's view; master is the environment's view.
interface garp_mem_bus_port_if #(
    parameter int unsigned LANES  = 24,
    parameter int unsigned LANE_W = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned BW = LANES * LANE_W;
    localparam int unsigned OW = $clog2(DEPTH) + 1;

    logic              io_req_valid;
    logic              io_req_ready;
    logic              io_req_write;
    logic [ADDR_W-1:0] io_req_addr;
    logic [BW-1:0]     io_req_data;
    logic [LANES-1:0]  io_req_mask;

    logic              io_mem_req_valid;
    logic              io_mem_req_ready;
    logic              io_mem_req_write;
    logic [ADDR_W-1:0] io_mem_req_addr;
    logic [BW-1:0]     io_mem_req_data;
    logic [LANES-1:0]  io_mem_req_mask;

    logic              io_mem_resp_valid;
    logic [BW-1:0]     io_mem_resp_data;

    logic              io_resp_valid;
    logic              io_resp_ready;
    logic [BW-1:0]     io_resp_data;

    logic [BW-1:0]     io_mem_bus_out;
    logic [OW-1:0]     io_outstanding;
    logic              io_err;

    modport slave (
        input  io_req_valid, io_req_write, io_req_addr, io_req_data, io_req_mask,
        input  io_mem_req_ready, io_mem_resp_valid, io_mem_resp_data, io_resp_ready,
        output io_req_ready, io_mem_req_valid, io_mem_req_write, io_mem_req_addr,
        output io_mem_req_data, io_mem_req_mask, io_resp_valid, io_resp_data,
        output io_mem_bus_out, io_outstanding, io_err
    );

    modport master (
        output io_req_valid, io_req_write, io_req_addr, io_req_data, io_req_mask,
        output io_mem_req_ready, io_mem_resp_valid, io_mem_resp_data, io_resp_ready,
        input  io_req_ready, io_mem_req_valid, io_mem_req_write, io_mem_req_addr,
        input  io_mem_req_data, io_mem_req_mask, io_resp_valid, io_resp_data,
        input  io_mem_bus_out, io_outstanding, io_err
    );
endinterface

// File: rtl/garp_mem_bus_port.sv
// Lane-packed memory bus port: request FIFO towards memory, credit-limited
// in-order response FIFO back to the array, and a registered last-load bus.
module garp_mem_bus_port #(
    parameter int unsigned LANES  = 24,
    parameter int unsigned LANE_W = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input logic                clk,
    input logic                reset,
    garp_mem_bus_port_if.slave bus
);
    localparam int unsigned BW = LANES * LANE_W;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    // Request FIFO storage and control
    logic              req_w_q [DEPTH];
    logic [ADDR_W-1:0] req_a_q [DEPTH];
    logic [BW-1:0]     req_d_q [DEPTH];
    logic [LANES-1:0]  req_m_q [DEPTH];
    logic [PW-1:0]     req_wp_q, req_wp_d, req_rp_q, req_rp_d;
    logic [CW-1:0]     req_cnt_q, req_cnt_d;

    // Response FIFO storage and control
    logic [BW-1:0]     rsp_d_q [DEPTH];
    logic [PW-1:0]     rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic [CW-1:0]     rsp_cnt_q, rsp_cnt_d;

    logic [CW-1:0]     outst_q, outst_d;
    logic [BW-1:0]     bus_out_q, bus_out_d;
    logic              err_q, err_d;

    logic req_ready_c, credit_ok_c, head_write_c, mem_req_valid_c;
    logic req_enq_c, req_deq_c, ld_issue_c;
    logic rsp_deq_c, spurious_c, rsp_acc_c, rsp_enq_c, overflow_c;

    // Loads only issue while every in-flight or buffered word has a free response slot
    assign req_ready_c     = req_cnt_q < CW'(DEPTH);
    assign credit_ok_c     = (SW'(outst_q) + SW'(rsp_cnt_q)) < SW'(DEPTH);
    assign head_write_c    = req_w_q[req_rp_q];
    assign mem_req_valid_c = (req_cnt_q != '0) && (head_write_c || credit_ok_c);

    assign req_enq_c  = bus.io_req_valid && req_ready_c;
    assign req_deq_c  = mem_req_valid_c && bus.io_mem_req_ready;
    assign ld_issue_c = req_deq_c && !head_write_c;

    // A response with nothing outstanding is a protocol error and is dropped
    assign rsp_deq_c  = (rsp_cnt_q != '0) && bus.io_resp_ready;
    assign spurious_c = bus.io_mem_resp_valid && (outst_q == '0);
    assign rsp_acc_c  = bus.io_mem_resp_valid && !spurious_c;
    assign rsp_enq_c  = rsp_acc_c && ((rsp_cnt_q != CW'(DEPTH)) || rsp_deq_c);
    assign overflow_c = rsp_acc_c && !rsp_enq_c;

    always_comb begin
        req_wp_d  = req_wp_q;
        req_rp_d  = req_rp_q;
        req_cnt_d = req_cnt_q;
        rsp_wp_d  = rsp_wp_q;
        rsp_rp_d  = rsp_rp_q;
        rsp_cnt_d = rsp_cnt_q;
        outst_d   = outst_q;
        bus_out_d = bus_out_q;
        err_d     = err_q;

        if (req_enq_c) req_wp_d = req_wp_q + PW'(1);
        if (req_deq_c) req_rp_d = req_rp_q + PW'(1);
        case ({req_enq_c, req_deq_c})
            2'b10:   req_cnt_d = req_cnt_q + CW'(1);
            2'b01:   req_cnt_d = req_cnt_q - CW'(1);
            default: req_cnt_d = req_cnt_q;
        endcase

        if (rsp_enq_c) rsp_wp_d = rsp_wp_q + PW'(1);
        if (rsp_deq_c) rsp_rp_d = rsp_rp_q + PW'(1);
        case ({rsp_enq_c, rsp_deq_c})
            2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
            2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
            default: rsp_cnt_d = rsp_cnt_q;
        endcase

        case ({ld_issue_c, rsp_acc_c})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        if (rsp_enq_c) bus_out_d = bus.io_mem_resp_data;
        if (spurious_c || overflow_c) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_wp_q  <= '0;
            req_rp_q  <= '0;
            req_cnt_q <= '0;
            rsp_wp_q  <= '0;
            rsp_rp_q  <= '0;
            rsp_cnt_q <= '0;
            outst_q   <= '0;
            bus_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            req_wp_q  <= req_wp_d;
            req_rp_q  <= req_rp_d;
            req_cnt_q <= req_cnt_d;
            rsp_wp_q  <= rsp_wp_d;
            rsp_rp_q  <= rsp_rp_d;
            rsp_cnt_q <= rsp_cnt_d;
            outst_q   <= outst_d;
            bus_out_q <= bus_out_d;
            err_q     <= err_d;
        end
    end

    // Payload storage needs no reset; validity lives in the counts
    always_ff @(posedge clk) begin
        if (req_enq_c) begin
            req_w_q[req_wp_q] <= bus.io_req_write;
            req_a_q[req_wp_q] <= bus.io_req_addr;
            req_d_q[req_wp_q] <= bus.io_req_data;
            req_m_q[req_wp_q] <= bus.io_req_mask;
        end
        if (rsp_enq_c) rsp_d_q[rsp_wp_q] <= bus.io_mem_resp_data;
    end

    assign bus.io_req_ready     = req_ready_c;
    assign bus.io_mem_req_valid = mem_req_valid_c;
    assign bus.io_mem_req_write = head_write_c;
    assign bus.io_mem_req_addr  = req_a_q[req_rp_q];
    assign bus.io_mem_req_data  = req_d_q[req_rp_q];
    assign bus.io_mem_req_mask  = req_m_q[req_rp_q];
    assign bus.io_resp_valid    = rsp_cnt_q != '0;
    assign bus.io_resp_data     = rsp_d_q[rsp_rp_q];
    assign bus.io_mem_bus_out   = bus_out_q;
    assign bus.io_outstanding   = outst_q;
    assign bus.io_err           = err_q;
endmodule

// File: tb/tb_garp_mem_bus_port.sv
// Self-checking bench for garp_mem_bus_port: directed scenarios plus random
// traffic compared against a queue-based model of the port.
module tb_garp_mem_bus_port;
    localparam int LANES = 24, LANE_W = 2, ADDR_W = 5, DEPTH = 4, BW = 48, OW = 3;
    localparam int LANES2 = 32, LANE_W2 = 4, ADDR_W2 = 8, DEPTH2 = 8, BW2 = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    garp_mem_bus_port_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();
    garp_mem_bus_port #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH))
        dut (.clk(clk), .reset(reset), .bus(bus));

    garp_mem_bus_port_if #(.LANES(LANES2), .LANE_W(LANE_W2), .ADDR_W(ADDR_W2), .DEPTH(DEPTH2)) bus2 ();
    garp_mem_bus_port #(.LANES(LANES2), .LANE_W(LANE_W2), .ADDR_W(ADDR_W2), .DEPTH(DEPTH2))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct packed {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [BW-1:0]     d;
        logic [LANES-1:0]  m;
    } req_t;

    // Model state: pending requests, buffered responses, loads in flight at memory
    req_t              mq[$];
    logic [BW-1:0]     rq[$];
    logic [ADDR_W-1:0] iss_q[$];
    int                m_out;
    logic [BW-1:0]     m_bus;
    bit                m_err;
    bit                last_enq;

    int n_vec = 0;
    int n_err = 0;

    function automatic bit exp_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit exp_mvalid();
        if (mq.size() == 0) return 1'b0;
        return mq[0].w || (m_out + rq.size() < DEPTH);
    endfunction

    task automatic drive_idle();
        bus.io_req_valid = 0; bus.io_req_write = 0; bus.io_req_addr = '0;
        bus.io_req_data = '0; bus.io_req_mask = '0; bus.io_mem_req_ready = 0;
        bus.io_mem_resp_valid = 0; bus.io_mem_resp_data = '0; bus.io_resp_ready = 0;
    endtask

    task automatic drive_idle2();
        bus2.io_req_valid = 0; bus2.io_req_write = 0; bus2.io_req_addr = '0;
        bus2.io_req_data = '0; bus2.io_req_mask = '0; bus2.io_mem_req_ready = 0;
        bus2.io_mem_resp_valid = 0; bus2.io_mem_resp_data = '0; bus2.io_resp_ready = 0;
    endtask

    // Memory side: return the oldest issued load (fixed pattern or random data)
    task automatic mem_return(input bit rnd);
        if (iss_q.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            bus.io_mem_resp_valid = 1'b1;
            if (rnd) bus.io_mem_resp_data = BW'({$urandom(), $urandom()});
            else     bus.io_mem_resp_data = BW'(iss_q[0]) + BW'(1);
            void'(iss_q.pop_front());
        end else begin
            bus.io_mem_resp_valid = 1'b0;
            bus.io_mem_resp_data  = '0;
        end
    endtask

    // One clock: decide transfers from current inputs and model state, then commit
    task automatic cyc();
        bit enq, deq, rdeq, rv;
        req_t nr, hd;
        logic [BW-1:0] rd;
        int out_pre, rq_pre;
        enq = bus.io_req_valid && exp_ready();
        deq = exp_mvalid() && bus.io_mem_req_ready;
        hd = '0;
        if (deq) hd = mq[0];
        nr.w = bus.io_req_write; nr.a = bus.io_req_addr;
        nr.d = bus.io_req_data;  nr.m = bus.io_req_mask;
        rdeq = (rq.size() > 0) && bus.io_resp_ready;
        rv = bus.io_mem_resp_valid;
        rd = bus.io_mem_resp_data;
        out_pre = m_out;
        rq_pre = rq.size();
        @(posedge clk);
        #1;
        if (deq) begin
            if (!hd.w) begin m_out++; iss_q.push_back(hd.a); end
            void'(mq.pop_front());
        end
        if (enq) mq.push_back(nr);
        if (rdeq) void'(rq.pop_front());
        if (rv) begin
            if (out_pre == 0) m_err = 1'b1;
            else begin
                m_out--;
                if (rq_pre == DEPTH && !rdeq) m_err = 1'b1;
                else begin rq.push_back(rd); m_bus = rd; end
            end
        end
        last_enq = enq;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_vec++; if (bus.io_mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_valid got %0b want 0", bus.io_mem_req_valid); end
        n_vec++; if (bus.io_resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %0b want 0", bus.io_resp_valid); end
        n_vec++; if (bus.io_outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got %0d want 0", bus.io_outstanding); end
        n_vec++; if (bus.io_mem_bus_out !== 48'd0) begin n_err++; $display("FAIL reset_bus_out got %h want 0", bus.io_mem_bus_out); end
        n_vec++; if (bus.io_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", bus.io_err); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (bus.io_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %0b want 1", bus.io_req_ready); end
    endtask

    task automatic test_store();
        logic [BW-1:0] sd;
        sd = {24{2'b10}};
        bus.io_mem_req_ready = 1;
        bus.io_req_valid = 1; bus.io_req_write = 1; bus.io_req_addr = 5'h1F;
        bus.io_req_data = sd; bus.io_req_mask = 24'h00F0F0;
        cyc();
        bus.io_req_valid = 0;
        n_vec++; if (bus.io_mem_req_valid !== 1'b1) begin n_err++; $display("FAIL store_valid got %0b want 1", bus.io_mem_req_valid); end
        n_vec++; if (bus.io_mem_req_write !== 1'b1) begin n_err++; $display("FAIL store_write got %0b want 1", bus.io_mem_req_write); end
        n_vec++; if (bus.io_mem_req_addr !== 5'h1F) begin n_err++; $display("FAIL store_addr got %h want 1f", bus.io_mem_req_addr); end
        n_vec++; if (bus.io_mem_req_data !== sd) begin n_err++; $display("FAIL store_data got %h want %h", bus.io_mem_req_data, sd); end
        n_vec++; if (bus.io_mem_req_mask !== 24'h00F0F0) begin n_err++; $display("FAIL store_mask got %h want 00f0f0", bus.io_mem_req_mask); end
        cyc();
        n_vec++; if (bus.io_mem_req_valid !== 1'b0) begin n_err++; $display("FAIL store_drained got %0b want 0", bus.io_mem_req_valid); end
        n_vec++; if (bus.io_outstanding !== 3'd0) begin n_err++; $display("FAIL store_outstanding got %0d want 0", bus.io_outstanding); end
        n_vec++; if (bus.io_resp_valid !== 1'b0) begin n_err++; $display("FAIL store_resp_valid got %0b want 0", bus.io_resp_valid); end
    endtask

    task automatic test_credit_stall();
        int pushed;
        bit sent;
        logic [BW-1:0] sdat;
        pushed = 0;
        drive_idle();
        bus.io_mem_req_ready = 1;
        for (int c = 0; c < 16; c++) begin
            bus.io_req_valid = (pushed < 5); bus.io_req_write = 0;
            bus.io_req_addr = ADDR_W'(pushed); bus.io_req_mask = '1;
            mem_return(1'b0);
            sent = bus.io_mem_resp_valid; sdat = bus.io_mem_resp_data;
            n_vec++; if (bus.io_mem_req_valid !== exp_mvalid()) begin n_err++; $display("FAIL credit_issue c=%0d got %0b want %0b", c, bus.io_mem_req_valid, exp_mvalid()); end
            cyc();
            if (last_enq) pushed++;
            if (sent) begin
                n_vec++; if (bus.io_mem_bus_out !== sdat) begin n_err++; $display("FAIL credit_bus_out got %h want %h", bus.io_mem_bus_out, sdat); end
            end
        end
        bus.io_req_valid = 0;
        n_vec++; if (bus.io_mem_req_valid !== 1'b0) begin n_err++; $display("FAIL credit_stalled got %0b want 0", bus.io_mem_req_valid); end
        n_vec++; if (bus.io_resp_data !== 48'h1) begin n_err++; $display("FAIL credit_head got %h want 1", bus.io_resp_data); end
        n_vec++; if (bus.io_mem_bus_out !== 48'h4) begin n_err++; $display("FAIL credit_bus_out4 got %h want 4", bus.io_mem_bus_out); end
        for (int k = 0; k < 5; k++) begin
            int t;
            t = 0;
            while (!bus.io_resp_valid && t < 20) begin mem_return(1'b0); cyc(); t++; end
            n_vec++;
            if (t >= 20) begin n_err++; $display("FAIL credit_timeout k=%0d got no resp want resp", k); end
            else if (bus.io_resp_data !== BW'(k + 1)) begin n_err++; $display("FAIL credit_seq k=%0d got %h want %h", k, bus.io_resp_data, BW'(k + 1)); end
            bus.io_resp_ready = 1; mem_return(1'b0);
            cyc();
            bus.io_resp_ready = 0;
        end
        drive_idle();
        n_vec++; if (bus.io_mem_bus_out !== 48'h5) begin n_err++; $display("FAIL credit_bus_out5 got %h want 5", bus.io_mem_bus_out); end
        n_vec++; if (bus.io_outstanding !== 3'd0) begin n_err++; $display("FAIL credit_outstanding got %0d want 0", bus.io_outstanding); end
    endtask

    task automatic test_full_fifo();
        req_t sent[$];
        req_t r;
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            r.w = 1'b1; r.a = ADDR_W'($urandom()); r.d = BW'({$urandom(), $urandom()}); r.m = LANES'($urandom());
            bus.io_req_valid = 1; bus.io_req_write = r.w; bus.io_req_addr = r.a;
            bus.io_req_data = r.d; bus.io_req_mask = r.m;
            sent.push_back(r);
            n_vec++; if (bus.io_req_ready !== (i < 4)) begin n_err++; $display("FAIL full_ready i=%0d got %0b want %0b", i, bus.io_req_ready, i < 4); end
            if (i < 4) cyc();
        end
        bus.io_mem_req_ready = 1;
        for (int c = 0; c < 15 && sent.size() > 0; c++) begin
            if (bus.io_mem_req_valid) begin
                n_vec++; if (bus.io_mem_req_addr !== sent[0].a) begin n_err++; $display("FAIL full_order_addr got %h want %h", bus.io_mem_req_addr, sent[0].a); end
                n_vec++; if (bus.io_mem_req_data !== sent[0].d) begin n_err++; $display("FAIL full_order_data got %h want %h", bus.io_mem_req_data, sent[0].d); end
                n_vec++; if (bus.io_mem_req_mask !== sent[0].m) begin n_err++; $display("FAIL full_order_mask got %h want %h", bus.io_mem_req_mask, sent[0].m); end
                void'(sent.pop_front());
            end
            cyc();
            if (last_enq) bus.io_req_valid = 0;
        end
        n_vec++; if (sent.size() != 0) begin n_err++; $display("FAIL full_issued got %0d left want 0", sent.size()); end
        drive_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.io_req_valid = 1'($urandom_range(0, 1)); bus.io_req_write = 1'($urandom_range(0, 1));
            bus.io_req_addr = ADDR_W'($urandom()); bus.io_req_data = BW'({$urandom(), $urandom()});
            bus.io_req_mask = LANES'($urandom());
            bus.io_mem_req_ready = ($urandom_range(0, 3) != 0);
            bus.io_resp_ready = ($urandom_range(0, 2) != 0);
            mem_return(1'b1);
            n_vec++; if (bus.io_req_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_req_ready c=%0d got %0b want %0b", c, bus.io_req_ready, exp_ready()); end
            n_vec++; if (bus.io_mem_req_valid !== exp_mvalid()) begin n_err++; $display("FAIL rnd_mem_valid c=%0d got %0b want %0b", c, bus.io_mem_req_valid, exp_mvalid()); end
            if (exp_mvalid()) begin
                n_vec++; if ({bus.io_mem_req_write, bus.io_mem_req_addr, bus.io_mem_req_data, bus.io_mem_req_mask} !== mq[0]) begin
                    n_err++; $display("FAIL rnd_mem_fields c=%0d got %h want %h", c, {bus.io_mem_req_write, bus.io_mem_req_addr, bus.io_mem_req_data, bus.io_mem_req_mask}, mq[0]); end
            end
            n_vec++; if (bus.io_resp_valid !== (rq.size() > 0)) begin n_err++; $display("FAIL rnd_resp_valid c=%0d got %0b want %0b", c, bus.io_resp_valid, rq.size() > 0); end
            if (rq.size() > 0) begin
                n_vec++; if (bus.io_resp_data !== rq[0]) begin n_err++; $display("FAIL rnd_resp_data c=%0d got %h want %h", c, bus.io_resp_data, rq[0]); end
            end
            n_vec++; if (bus.io_mem_bus_out !== m_bus) begin n_err++; $display("FAIL rnd_bus_out c=%0d got %h want %h", c, bus.io_mem_bus_out, m_bus); end
            n_vec++; if (bus.io_outstanding !== OW'(m_out)) begin n_err++; $display("FAIL rnd_outstanding c=%0d got %0d want %0d", c, bus.io_outstanding, m_out); end
            n_vec++; if (bus.io_err !== m_err) begin n_err++; $display("FAIL rnd_err c=%0d got %0b want %0b", c, bus.io_err, m_err); end
            cyc();
        end
        drive_idle();
        bus.io_mem_req_ready = 1; bus.io_resp_ready = 1;
        for (int c = 0; c < 60; c++) begin
            if (mq.size() == 0 && rq.size() == 0 && iss_q.size() == 0 && m_out == 0) break;
            mem_return(1'b0);
            cyc();
        end
        drive_idle();
        n_vec++; if (bus.io_outstanding !== 3'd0) begin n_err++; $display("FAIL drain_outstanding got %0d want 0", bus.io_outstanding); end
        n_vec++; if (bus.io_resp_valid !== 1'b0) begin n_err++; $display("FAIL drain_resp_valid got %0b want 0", bus.io_resp_valid); end
    endtask

    task automatic test_spurious();
        logic [BW-1:0] prev;
        drive_idle();
        prev = m_bus;
        bus.io_mem_resp_valid = 1; bus.io_mem_resp_data = BW'({$urandom(), $urandom()}) | BW'(1);
        cyc();
        drive_idle();
        n_vec++; if (bus.io_err !== 1'b1) begin n_err++; $display("FAIL spur_err got %0b want 1", bus.io_err); end
        n_vec++; if (bus.io_resp_valid !== 1'b0) begin n_err++; $display("FAIL spur_resp_valid got %0b want 0", bus.io_resp_valid); end
        n_vec++; if (bus.io_mem_bus_out !== prev) begin n_err++; $display("FAIL spur_bus_out got %h want %h", bus.io_mem_bus_out, prev); end
        n_vec++; if (bus.io_outstanding !== 3'd0) begin n_err++; $display("FAIL spur_outstanding got %0d want 0", bus.io_outstanding); end
        repeat (3) cyc();
        n_vec++; if (bus.io_err !== 1'b1) begin n_err++; $display("FAIL spur_sticky got %0b want 1", bus.io_err); end
    endtask

    task automatic test_reset_midop();
        int t;
        drive_idle();
        bus.io_mem_req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.io_req_valid = 1; bus.io_req_write = 0; bus.io_req_addr = ADDR_W'(i);
            cyc();
        end
        bus.io_req_valid = 0;
        t = 0;
        while (iss_q.size() < 3 && t < 10) begin cyc(); t++; end
        bus.io_mem_resp_valid = 1; bus.io_mem_resp_data = 48'h1234_5678_9ABC;
        void'(iss_q.pop_front());
        cyc();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            bus.io_req_valid = 1; bus.io_req_write = 1; bus.io_req_addr = ADDR_W'(i + 8);
            cyc();
        end
        bus.io_req_valid = 0;
        n_vec++; if (bus.io_outstanding !== 3'd2) begin n_err++; $display("FAIL mid_pre_outstanding got %0d want 2", bus.io_outstanding); end
        n_vec++; if (bus.io_mem_bus_out !== 48'h1234_5678_9ABC) begin n_err++; $display("FAIL mid_pre_bus_out got %h want 123456789abc", bus.io_mem_bus_out); end
        #2;
        reset = 1'b0;
        #1;
        n_vec++; if (bus.io_mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_mem_req_valid got %0b want 0", bus.io_mem_req_valid); end
        n_vec++; if (bus.io_outstanding !== 3'd0) begin n_err++; $display("FAIL mid_outstanding got %0d want 0", bus.io_outstanding); end
        n_vec++; if (bus.io_mem_bus_out !== 48'd0) begin n_err++; $display("FAIL mid_bus_out got %h want 0", bus.io_mem_bus_out); end
        n_vec++; if (bus.io_err !== 1'b0) begin n_err++; $display("FAIL mid_err got %0b want 0", bus.io_err); end
        mq.delete(); rq.delete(); iss_q.delete();
        m_out = 0; m_bus = '0; m_err = 1'b0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (bus.io_req_ready !== 1'b1) begin n_err++; $display("FAIL mid_req_ready got %0b want 1", bus.io_req_ready); end
        n_vec++; if (bus.io_resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_resp_valid got %0b want 0", bus.io_resp_valid); end
    endtask

    task automatic test_param();
        logic [BW2-1:0] v;
        v = 128'h0123456789ABCDEF_FEDCBA9876543210;
        drive_idle2();
        bus2.io_mem_req_ready = 1;
        bus2.io_req_valid = 1; bus2.io_req_write = 0; bus2.io_req_addr = 8'hA5;
        cyc();
        bus2.io_req_valid = 0;
        n_vec++; if (bus2.io_mem_req_valid !== 1'b1) begin n_err++; $display("FAIL p_mem_valid got %0b want 1", bus2.io_mem_req_valid); end
        n_vec++; if (bus2.io_mem_req_addr !== 8'hA5) begin n_err++; $display("FAIL p_addr got %h want a5", bus2.io_mem_req_addr); end
        cyc();
        n_vec++; if (bus2.io_outstanding !== 4'd1) begin n_err++; $display("FAIL p_outstanding1 got %0d want 1", bus2.io_outstanding); end
        bus2.io_mem_resp_valid = 1; bus2.io_mem_resp_data = v;
        cyc();
        bus2.io_mem_resp_valid = 0; bus2.io_mem_resp_data = '0;
        n_vec++; if (bus2.io_resp_valid !== 1'b1) begin n_err++; $display("FAIL p_resp_valid got %0b want 1", bus2.io_resp_valid); end
        n_vec++; if (bus2.io_resp_data !== v) begin n_err++; $display("FAIL p_resp_data got %h want %h", bus2.io_resp_data, v); end
        n_vec++; if (bus2.io_mem_bus_out !== v) begin n_err++; $display("FAIL p_bus_out got %h want %h", bus2.io_mem_bus_out, v); end
        n_vec++; if (bus2.io_outstanding !== 4'd0) begin n_err++; $display("FAIL p_outstanding0 got %0d want 0", bus2.io_outstanding); end
        bus2.io_resp_ready = 1;
        cyc();
        bus2.io_resp_ready = 0;
        n_vec++; if (bus2.io_resp_valid !== 1'b0) begin n_err++; $display("FAIL p_popped got %0b want 0", bus2.io_resp_valid); end
    endtask

    initial begin
        m_out = 0; m_bus = '0; m_err = 1'b0; last_enq = 1'b0;
        reset = 1'b0;
        drive_idle();
        drive_idle2();
        test_reset();
        test_store();
        test_credit_stall();
        test_full_fifo();
        test_random();
        test_spurious();
        test_reset_midop();
        test_param();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
